// File: rtl/logic_pkg.sv
// Shared definitions for the pipelined logic unit: opcode encoding and default sizing.
package logic_pkg;

  typedef enum logic [2:0] {
    OP_AND   = 3'd0,
    OP_OR    = 3'd1,
    OP_NOTA  = 3'd2,
    OP_NAND  = 3'd3,
    OP_NOR   = 3'd4,
    OP_XOR   = 3'd5,
    OP_XNOR  = 3'd6,
    OP_PASSB = 3'd7
  } op_e;

  localparam int DEF_WIDTH  = 8;
  localparam int DEF_STAGES = 2;
  localparam int DEF_CNT_W  = 16;

endpackage

// File: rtl/logic_func.sv
// Purely combinational opcode-to-result function; shared with the gate block tests.
module logic_func
  import logic_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic [WIDTH-1:0] y
);

  always_comb begin
    y = '0;
    unique case (op_e'(op))
      OP_AND:   y = a & b;
      OP_OR:    y = a | b;
      OP_NOTA:  y = ~a;
      OP_NAND:  y = ~(a & b);
      OP_NOR:   y = ~(a | b);
      OP_XOR:   y = a ^ b;
      OP_XNOR:  y = ~(a ^ b);
      OP_PASSB: y = b;
    endcase
  end

endmodule

// File: rtl/logic_unit_pipe.sv
// Elastic STAGES-deep pipeline around logic_func, adding zero/parity flags and a
// counter of completed output handshakes.
module logic_unit_pipe
  import logic_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int STAGES = DEF_STAGES,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Y,
  output logic             zero,
  output logic             parity,
  output logic [CNT_W-1:0] op_count
);

  logic [WIDTH-1:0]  func_y;
  logic [STAGES-1:0] v_q, v_d, z_q, z_d, p_q, p_d;
  logic [STAGES-1:0] up_v, up_z, up_p, ready;
  logic [WIDTH-1:0]  y_q [STAGES];
  logic [WIDTH-1:0]  y_d [STAGES];
  logic [WIDTH-1:0]  up_y [STAGES];
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic_func #(.WIDTH(WIDTH)) u_func (
    .a  (A),
    .b  (B),
    .op (op),
    .y  (func_y)
  );

  // A stage can take new data unless it and every stage after it are full and the
  // consumer is stalling; written flat so there is no combinational ready chain.
  generate
    for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
      if (gi == 0) begin : g_head
        assign up_v[gi] = in_valid;
        assign up_y[gi] = func_y;
        assign up_z[gi] = ~|func_y;
        assign up_p[gi] = ^func_y;
      end else begin : g_body
        assign up_v[gi] = v_q[gi-1];
        assign up_y[gi] = y_q[gi-1];
        assign up_z[gi] = z_q[gi-1];
        assign up_p[gi] = p_q[gi-1];
      end
      assign ready[gi] = out_ready | ~(&v_q[STAGES-1:gi]);
    end
  endgenerate

  always_comb begin
    v_d = v_q;
    z_d = z_q;
    p_d = p_q;
    y_d = y_q;
    for (int k = 0; k < STAGES; k++) begin
      if (ready[k]) begin
        v_d[k] = up_v[k];
        if (up_v[k]) begin
          y_d[k] = up_y[k];
          z_d[k] = up_z[k];
          p_d[k] = up_p[k];
        end
      end
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (out_valid && out_ready) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v_q   <= '0;
      z_q   <= '0;
      p_q   <= '0;
      cnt_q <= '0;
      for (int k = 0; k < STAGES; k++) begin
        y_q[k] <= '0;
      end
    end else begin
      v_q   <= v_d;
      z_q   <= z_d;
      p_q   <= p_d;
      y_q   <= y_d;
      cnt_q <= cnt_d;
    end
  end

  assign in_ready  = ready[0];
  assign out_valid = v_q[STAGES-1];
  assign Y         = y_q[STAGES-1];
  assign zero      = z_q[STAGES-1];
  assign parity    = p_q[STAGES-1];
  assign op_count  = cnt_q;

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Scoreboard bench for logic_unit_pipe across three parameter sets
// (8/2 with a 4-bit counter, 1/1, 32/4).
module tb_logic_unit_pipe;

  localparam int ND = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;

  logic        in_valid  [ND];
  logic        out_ready [ND];
  logic [31:0] a_in      [ND];
  logic [31:0] b_in      [ND];
  logic [2:0]  op_in     [ND];
  logic        in_ready_w  [ND];
  logic        out_valid_w [ND];
  logic        zero_w      [ND];
  logic        parity_w    [ND];
  logic [31:0] y_w   [ND];
  logic [31:0] cnt_w [ND];
  bit          lat_chk [ND];

  logic [7:0]  y0;
  logic [0:0]  y1;
  logic [31:0] y2;
  logic [3:0]  c0;
  logic [15:0] c1, c2;

  logic_unit_pipe #(.WIDTH(8), .STAGES(2), .CNT_W(4)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready_w[0]),
    .A(a_in[0][7:0]), .B(b_in[0][7:0]), .op(op_in[0]),
    .out_valid(out_valid_w[0]), .out_ready(out_ready[0]), .Y(y0),
    .zero(zero_w[0]), .parity(parity_w[0]), .op_count(c0));

  logic_unit_pipe #(.WIDTH(1), .STAGES(1), .CNT_W(16)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready_w[1]),
    .A(a_in[1][0:0]), .B(b_in[1][0:0]), .op(op_in[1]),
    .out_valid(out_valid_w[1]), .out_ready(out_ready[1]), .Y(y1),
    .zero(zero_w[1]), .parity(parity_w[1]), .op_count(c1));

  logic_unit_pipe #(.WIDTH(32), .STAGES(4), .CNT_W(16)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid[2]), .in_ready(in_ready_w[2]),
    .A(a_in[2]), .B(b_in[2]), .op(op_in[2]),
    .out_valid(out_valid_w[2]), .out_ready(out_ready[2]), .Y(y2),
    .zero(zero_w[2]), .parity(parity_w[2]), .op_count(c2));

  assign y_w[0]   = {24'd0, y0};
  assign y_w[1]   = {31'd0, y1};
  assign y_w[2]   = y2;
  assign cnt_w[0] = {28'd0, c0};
  assign cnt_w[1] = {16'd0, c1};
  assign cnt_w[2] = {16'd0, c2};

  function automatic int wid(int d);
    return (d == 0) ? 8 : (d == 1) ? 1 : 32;
  endfunction

  function automatic int stg(int d);
    return (d == 0) ? 2 : (d == 1) ? 1 : 4;
  endfunction

  function automatic logic [31:0] dmask(int d);
    return (wid(d) == 32) ? 32'hFFFF_FFFF : ((32'd1 << wid(d)) - 32'd1);
  endfunction

  function automatic logic [31:0] cmask(int d);
    return (d == 0) ? 32'h0000_000F : 32'h0000_FFFF;
  endfunction

  // Reference: the eight bitwise functions straight from the opcode table.
  function automatic logic [31:0] model(int o, logic [31:0] a, logic [31:0] b, int d);
    logic [31:0] r;
    case (o)
      0:       r = a & b;
      1:       r = a | b;
      2:       r = ~a;
      3:       r = ~(a & b);
      4:       r = ~(a | b);
      5:       r = a ^ b;
      6:       r = ~(a ^ b);
      default: r = b;
    endcase
    return r & dmask(d);
  endfunction

  task automatic chk(string nm, int d, logic [31:0] act, logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s dut%0d: got %h, required %h (cycle %0d)", nm, d, act, req, cyc);
    end
  endtask

  // Scoreboard and monitor
  typedef struct {
    logic [31:0] y;
    logic        z;
    logic        p;
    int          cyc;
  } exp_t;

  exp_t        sb [ND][$];
  int          cnt_m   [ND];
  bit          stall_q [ND];
  logic [31:0] prev_y  [ND];
  logic        prev_z  [ND];
  logic        prev_p  [ND];

  always @(negedge clk) begin
    for (int d = 0; d < ND; d++) begin
      if (rst) begin
        sb[d].delete();
        cnt_m[d]   = 0;
        stall_q[d] = 1'b0;
      end else begin
        chk("op_count", d, cnt_w[d], 32'(cnt_m[d]) & cmask(d));
        if (stall_q[d]) begin
          chk("stall_valid",  d, {31'd0, out_valid_w[d]}, 32'd1);
          chk("stall_y",      d, y_w[d], prev_y[d]);
          chk("stall_flags",  d, {30'd0, zero_w[d], parity_w[d]}, {30'd0, prev_z[d], prev_p[d]});
        end
        if (out_valid_w[d] && out_ready[d]) begin
          if (sb[d].size() == 0) begin
            chk("unexpected_output", d, 32'd1, 32'd0);
          end else begin
            exp_t e;
            e = sb[d].pop_front();
            $display("dut%0d out y=%h zero=%b parity=%b (expected y=%h zero=%b parity=%b)",
                     d, y_w[d], zero_w[d], parity_w[d], e.y, e.z, e.p);
            chk("y",      d, y_w[d], e.y);
            chk("zero",   d, {31'd0, zero_w[d]}, {31'd0, e.z});
            chk("parity", d, {31'd0, parity_w[d]}, {31'd0, e.p});
            if (lat_chk[d]) chk("latency", d, 32'(cyc - e.cyc), 32'(stg(d)));
          end
          cnt_m[d]++;
        end
        stall_q[d] = out_valid_w[d] && !out_ready[d];
        prev_y[d]  = y_w[d];
        prev_z[d]  = zero_w[d];
        prev_p[d]  = parity_w[d];
        if (in_valid[d] && in_ready_w[d]) begin
          exp_t e;
          e.y   = model(int'(op_in[d]), a_in[d], b_in[d], d);
          e.z   = (e.y == 32'd0);
          e.p   = ^e.y;
          e.cyc = cyc;
          sb[d].push_back(e);
        end
      end
    end
  end

  // Stimulus helpers; every task starts and ends 1 time unit after a rising edge.
  task automatic cycles(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(int d, logic [31:0] a, logic [31:0] b, logic [2:0] o);
    bit acc = 1'b0;
    a_in[d] = a & dmask(d);
    b_in[d] = b & dmask(d);
    op_in[d] = o;
    in_valid[d] = 1'b1;
    for (int i = 0; i < 60 && !acc; i++) begin
      @(negedge clk);
      acc = in_ready_w[d];
      @(posedge clk);
      #1;
    end
    in_valid[d] = 1'b0;
    if (!acc) chk("send_timeout", d, 32'd0, 32'd1);
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    cycles(1);
    rst = 1'b0;
  endtask

  task automatic chk_idle(string nm, int d);
    chk({nm, "_out_valid"}, d, {31'd0, out_valid_w[d]}, 32'd0);
    chk({nm, "_y"},         d, y_w[d], 32'd0);
    chk({nm, "_flags"},     d, {30'd0, zero_w[d], parity_w[d]}, 32'd0);
    chk({nm, "_count"},     d, cnt_w[d], 32'd0);
    chk({nm, "_in_ready"},  d, {31'd0, in_ready_w[d]}, 32'd1);
  endtask

  task automatic random_phase(int d, int n);
    bit done = 1'b0;
    fork
      begin
        for (int i = 0; i < n; i++) begin
          if ($urandom_range(3) == 0) cycles(1);
          send(d, $urandom, $urandom, 3'($urandom_range(7)));
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          out_ready[d] = ($urandom_range(2) != 0);
          cycles(1);
        end
      end
    join
    out_ready[d] = 1'b1;
    cycles(stg(d) + 3);
    chk("drain_empty", d, 32'(sb[d].size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int d = 0; d < ND; d++) begin
      in_valid[d] = 1'b0;
      out_ready[d] = 1'b1;
      a_in[d] = '0;
      b_in[d] = '0;
      op_in[d] = '0;
      lat_chk[d] = 1'b0;
    end
    rst = 1'b1;
    cycles(3);
    rst = 1'b0;
    for (int d = 0; d < ND; d++) chk_idle("reset", d);

    // Truth table with no backpressure; latency checked on every result.
    for (int d = 0; d < ND; d++) begin
      lat_chk[d] = 1'b1;
      for (int o = 0; o < 8; o++) send(d, 32'hCCCC_CCCC, 32'hAAAA_AAAA, 3'(o));
      cycles(stg(d) + 2);
      lat_chk[d] = 1'b0;
      chk("truth_count", d, cnt_w[d], 32'd8);
    end

    // Flag corner cases on the 8-bit instance.
    send(0, 32'hF0, 32'h0F, 3'd0);
    send(0, 32'hF0, 32'h0F, 3'd5);
    send(0, 32'h01, 32'h07, 3'd7);
    cycles(4);

    // Backpressure: two accepted, third held off until the head drains.
    out_ready[0] = 1'b0;
    send(0, 32'h12, 32'h34, 3'd5);
    send(0, 32'h56, 32'h78, 3'd1);
    a_in[0] = 32'h9A;
    b_in[0] = 32'hBC;
    op_in[0] = 3'd6;
    in_valid[0] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_in_ready_low", 0, {31'd0, in_ready_w[0]}, 32'd0);
      chk("bp_out_valid",    0, {31'd0, out_valid_w[0]}, 32'd1);
      @(posedge clk);
      #1;
    end
    out_ready[0] = 1'b1;
    @(negedge clk);
    chk("bp_accept_on_drain", 0, {31'd0, in_ready_w[0]}, 32'd1);
    @(posedge clk);
    #1;
    in_valid[0] = 1'b0;
    cycles(4);
    chk("bp_drain_empty", 0, 32'(sb[0].size()), 32'd0);

    // Reset with a full pipeline and a pending offer.
    pulse_rst();
    for (int i = 0; i < 5; i++) send(0, 32'(i * 37), 32'(i * 91), 3'(i));
    cycles(4);
    chk("pre_reset_count", 0, cnt_w[0], 32'd5);
    out_ready[0] = 1'b0;
    send(0, 32'h11, 32'h22, 3'd1);
    send(0, 32'h33, 32'h44, 3'd5);
    a_in[0] = 32'h55;
    b_in[0] = 32'h66;
    in_valid[0] = 1'b1;
    rst = 1'b1;
    cycles(1);
    rst = 1'b0;
    in_valid[0] = 1'b0;
    chk_idle("mid_reset", 0);
    out_ready[0] = 1'b1;
    cycles(5);

    // Counter wrap on the 4-bit counter: 17 handshakes end at 1.
    pulse_rst();
    for (int i = 0; i < 17; i++) send(0, $urandom, $urandom, 3'($urandom_range(7)));
    cycles(4);
    chk("wrap_count", 0, cnt_w[0], 32'd1);

    for (int d = 0; d < ND; d++) random_phase(d, 120);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
